// File: rtl/can_tx_scheduler.sv
// CAN transmit scheduler: arbitrates N_REQ requesters by lowest CAN ID onto a
// single frame generator, retransmits on error, and enforces an idle-bus gap
// between frames.
//
// Handshake: a requester holds req_valid and its payload stable until it sees
// its req_ack bit pulse for one cycle. After that pulse the frame is owned by
// the scheduler, and req_valid from that requester is ignored until the FSM
// returns to IDLE. Toward the generator, gen_start pulses for one cycle with
// gen_payload already stable. The generator answers with a single-cycle
// gen_ok or gen_err. The scheduler ignores either pulse outside WAIT.
module can_tx_scheduler #(
    parameter int N_REQ      = 4,
    parameter int MAX_RETRY  = 3,
    parameter int IFS_CYCLES = 11,
    parameter int TIMEOUT    = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*75-1:0] req_payload,
    output logic [N_REQ-1:0]   req_ack,
    output logic [N_REQ-1:0]   tx_done,
    output logic [N_REQ-1:0]   tx_fail,
    output logic [75:0]        gen_payload,
    output logic               gen_start,
    input  logic               gen_ok,
    input  logic               gen_err,
    input  logic               bus_idle,
    output logic               busy,
    output logic [2:0]         grant_idx,
    output logic [2:0]         retry_cnt,
    output logic [2:0]         state_o
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(IFS_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t             state_q;
    logic [N_REQ-1:0]   req_ack_q;
    logic [N_REQ-1:0]   tx_done_q;
    logic [N_REQ-1:0]   tx_fail_q;
    logic [75:0]        gen_payload_q;
    logic               gen_start_q;
    logic [2:0]         grant_idx_q;
    logic [2:0]         retry_cnt_q;
    logic               retry_pend_q;
    logic [TW-1:0]      tmo_q;
    logic [GW-1:0]      gap_q;

    logic               win_found;
    logic [2:0]         win_idx;
    logic [10:0]        win_id;
    logic [74:0]        win_pay;
    logic               attempt_err;

    // Priority pick: lowest CAN ID wins; strict compare keeps lowest index on ties.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 3'd0;
        win_id    = 11'h7FF;
        win_pay   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_valid[i] && (!win_found || (req_payload[75*i+64 +: 11] < win_id))) begin
                win_found = 1'b1;
                win_idx   = 3'(i);
                win_id    = req_payload[75*i+64 +: 11];
                win_pay   = req_payload[75*i +: 75];
            end
        end
    end

    // An attempt fails on a generator error or when the generator stays silent too long.
    assign attempt_err = gen_err || (tmo_q == TW'(TIMEOUT - 1));

    // Scheduler FSM; all pulse outputs default low each cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            req_ack_q     <= '0;
            tx_done_q     <= '0;
            tx_fail_q     <= '0;
            gen_payload_q <= '0;
            gen_start_q   <= 1'b0;
            grant_idx_q   <= 3'd0;
            retry_cnt_q   <= 3'd0;
            retry_pend_q  <= 1'b0;
            tmo_q         <= '0;
            gap_q         <= '0;
        end else begin
            req_ack_q   <= '0;
            tx_done_q   <= '0;
            tx_fail_q   <= '0;
            gen_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (win_found && bus_idle) begin
                        grant_idx_q   <= win_idx;
                        gen_payload_q <= {1'b0, win_pay};
                        retry_cnt_q   <= 3'd0;
                        retry_pend_q  <= 1'b0;
                        req_ack_q     <= N_REQ'(1) << win_idx;
                        state_q       <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    gen_start_q <= 1'b1;
                    state_q     <= S_START;
                end
                S_START: begin
                    tmo_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (gen_ok) begin
                        tx_done_q    <= N_REQ'(1) << grant_idx_q;
                        retry_pend_q <= 1'b0;
                        gap_q        <= '0;
                        state_q      <= S_GAP;
                    end else if (attempt_err) begin
                        if (retry_cnt_q < 3'(MAX_RETRY)) begin
                            retry_cnt_q  <= retry_cnt_q + 3'd1;
                            retry_pend_q <= 1'b1;
                        end else begin
                            tx_fail_q    <= N_REQ'(1) << grant_idx_q;
                            retry_pend_q <= 1'b0;
                        end
                        gap_q   <= '0;
                        state_q <= S_GAP;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                S_GAP: begin
                    if (!bus_idle) begin
                        gap_q <= '0;
                    end else if (gap_q == GW'(IFS_CYCLES - 1)) begin
                        gap_q <= '0;
                        if (retry_pend_q) begin
                            gen_start_q <= 1'b1;
                            state_q     <= S_START;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        gap_q <= gap_q + GW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ack     = req_ack_q;
    assign tx_done     = tx_done_q;
    assign tx_fail     = tx_fail_q;
    assign gen_payload = gen_payload_q;
    assign gen_start   = gen_start_q;
    assign grant_idx   = grant_idx_q;
    assign retry_cnt   = retry_cnt_q;
    assign busy        = (state_q != S_IDLE);
    assign state_o     = state_q;

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Testbench for can_tx_scheduler: directed scenarios push the expected output
// events into a queue; a negedge monitor pops and compares every pulse the
// DUT presents (req_ack, gen_start, tx_done, tx_fail), and the stimulus adds
// direct latency/state checks.
module tb_can_tx_scheduler;

    localparam int N = 4;
    localparam logic [2:0] EV_ACK   = 3'd1;
    localparam logic [2:0] EV_START = 3'd2;
    localparam logic [2:0] EV_DONE  = 3'd3;
    localparam logic [2:0] EV_FAIL  = 3'd4;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*75-1:0] req_payload;
    logic [N-1:0]    req_ack;
    logic [N-1:0]    tx_done;
    logic [N-1:0]    tx_fail;
    logic [75:0]     gen_payload;
    logic            gen_start;
    logic            gen_ok;
    logic            gen_err;
    logic            bus_idle;
    logic            busy;
    logic [2:0]      grant_idx;
    logic [2:0]      retry_cnt;
    logic [2:0]      state_o;

    int n_checks = 0;
    int n_pass   = 0;
    logic [81:0] exp_q[$];

    can_tx_scheduler #(.N_REQ(N), .MAX_RETRY(3), .IFS_CYCLES(11), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_payload(req_payload), .req_ack(req_ack),
        .tx_done(tx_done), .tx_fail(tx_fail),
        .gen_payload(gen_payload), .gen_start(gen_start),
        .gen_ok(gen_ok), .gen_err(gen_err), .bus_idle(bus_idle),
        .busy(busy), .grant_idx(grant_idx), .retry_cnt(retry_cnt), .state_o(state_o)
    );

    // Clock and reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got=%0h required=%0h", name, got, exp);
    endtask

    function automatic logic [74:0] mk(input logic [10:0] id, input logic [63:0] d);
        return {id, d};
    endfunction

    function automatic logic [81:0] ev(input logic [2:0] t, input int idx, input logic [74:0] p);
        return {t, 3'(idx), 1'b0, p};
    endfunction

    // Scoreboard monitor
    task automatic sb_pop(input logic [81:0] got);
        logic [81:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL sb_unexpected: got event=%0h required=none", got);
        end else begin
            e = exp_q.pop_front();
            check("sb_event", got, e);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++)
                if (req_ack[i]) sb_pop({EV_ACK, 3'(i), gen_payload});
            if (gen_start) sb_pop({EV_START, grant_idx, gen_payload});
            for (int i = 0; i < N; i++)
                if (tx_done[i]) sb_pop({EV_DONE, 3'(i), gen_payload});
            for (int i = 0; i < N; i++)
                if (tx_fail[i]) sb_pop({EV_FAIL, 3'(i), gen_payload});
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int budget, output logic [N-1:0] ack, output int n);
        ack = '0;
        n = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (req_ack != '0) begin
                ack = req_ack;
                n = k + 1;
                return;
            end
        end
        n_checks++;
        $display("FAIL wait_ack: no ack within %0d cycles", budget);
    endtask

    task automatic wait_start(input int budget, output int n);
        n = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (gen_start) begin
                n = k + 1;
                return;
            end
        end
        n_checks++;
        $display("FAIL wait_start: no gen_start within %0d cycles", budget);
    endtask

    // Called at the START-cycle negedge; pulses in WAIT cycle `delay`.
    // mode 0 = gen_err, 1 = gen_ok, 2 = both.
    task automatic gen_reply(input int delay, input int mode);
        tick();
        repeat (delay - 1) tick();
        gen_ok  = (mode != 0);
        gen_err = (mode != 1);
        tick();
        gen_ok  = 1'b0;
        gen_err = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (!busy) return;
        end
        n_checks++;
        $display("FAIL wait_idle: busy still high after %0d cycles", budget);
    endtask

    task automatic two_req(input string tag, input int first, input int second,
                           input logic [74:0] pf, input logic [74:0] ps);
        logic [N-1:0] ack;
        int n;
        exp_q.push_back(ev(EV_ACK, first, pf));
        exp_q.push_back(ev(EV_START, first, pf));
        exp_q.push_back(ev(EV_DONE, first, pf));
        exp_q.push_back(ev(EV_ACK, second, ps));
        exp_q.push_back(ev(EV_START, second, ps));
        exp_q.push_back(ev(EV_DONE, second, ps));
        tick();
        req_valid[first]  = 1'b1;
        req_valid[second] = 1'b1;
        wait_ack(10, ack, n);
        check({tag, "_ack_first"}, ack, N'(1) << first);
        tick();
        req_valid[first] = 1'b0;
        wait_start(5, n);
        gen_reply(5, 1);
        wait_ack(40, ack, n);
        check({tag, "_ack_second"}, ack, N'(1) << second);
        check({tag, "_regrant_after_gap"}, n, 13);
        tick();
        req_valid[second] = 1'b0;
        wait_start(5, n);
        gen_reply(5, 1);
        wait_idle(40);
    endtask

    // Stimulus
    initial begin
        logic [N-1:0] ack;
        logic [74:0] p0, p1, p2, p3;
        int n;

        rst = 1'b0;
        req_valid = '0;
        req_payload = '0;
        gen_ok = 1'b0;
        gen_err = 1'b0;
        bus_idle = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_payload", gen_payload, 0);
        check("rst_pulses", {req_ack, tx_done, tx_fail, gen_start}, 0);
        check("rst_counters", {grant_idx, retry_cnt, state_o}, 0);
        tick();
        rst = 1'b1;
        tick();

        // Single request
        p0 = mk(11'h581, 64'h0123456789ABCDEF);
        req_payload[0 +: 75] = p0;
        exp_q.push_back(ev(EV_ACK, 0, p0));
        exp_q.push_back(ev(EV_START, 0, p0));
        exp_q.push_back(ev(EV_DONE, 0, p0));
        tick();
        req_valid = 4'b0001;
        wait_start(10, n);
        check("s1_req_to_start", n, 3);
        check("s1_payload", gen_payload, 76'h5810123456789ABCDEF);
        req_valid = '0;
        gen_reply(120, 1);
        @(negedge clk);
        check("s1_done_latency", tx_done, 4'b0001);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("s1_gap_busy_cycles", n, 11);

        // Generator pulses in IDLE must be ignored
        tick();
        gen_ok = 1'b1;
        gen_err = 1'b1;
        tick();
        gen_ok = 1'b0;
        gen_err = 1'b0;
        repeat (3) tick();
        check("idle_ignore_busy", busy, 0);

        // Priority by id, then tie by index
        p0 = mk(11'h600, 64'hAAAA_0000_0000_0000);
        p2 = mk(11'h181, 64'h2222_0000_0000_0002);
        req_payload[0 +: 75]   = p0;
        req_payload[150 +: 75] = p2;
        two_req("s2", 2, 0, p2, p0);
        p1 = mk(11'h181, 64'h1111_0000_0000_0001);
        p3 = mk(11'h181, 64'h3333_0000_0000_0003);
        req_payload[75 +: 75]  = p1;
        req_payload[225 +: 75] = p3;
        two_req("s2tie", 1, 3, p1, p3);

        // Retry: err, err, then ok+err together (ok wins)
        p1 = mk(11'h123, 64'hDEADBEEF00C0FFEE);
        req_payload[75 +: 75] = p1;
        exp_q.push_back(ev(EV_ACK, 1, p1));
        repeat (3) exp_q.push_back(ev(EV_START, 1, p1));
        exp_q.push_back(ev(EV_DONE, 1, p1));
        tick();
        req_valid = 4'b0010;
        wait_ack(10, ack, n);
        tick();
        req_valid = '0;
        wait_start(5, n);
        gen_reply(3, 0);
        check("s3_retry_cnt1", retry_cnt, 1);
        wait_start(30, n);
        check("s3_retry_gap", n, 12);
        gen_reply(3, 0);
        wait_start(30, n);
        check("s3_retry_gap2", n, 12);
        gen_reply(3, 2);
        @(negedge clk);
        check("s3_done", tx_done, 4'b0010);
        check("s3_retry_cnt2", retry_cnt, 2);
        wait_idle(40);

        // Exhaustion
        p3 = mk(11'h7FF, 64'hFFFF_FFFF_FFFF_FFFF);
        req_payload[225 +: 75] = p3;
        exp_q.push_back(ev(EV_ACK, 3, p3));
        repeat (4) exp_q.push_back(ev(EV_START, 3, p3));
        exp_q.push_back(ev(EV_FAIL, 3, p3));
        tick();
        req_valid = 4'b1000;
        wait_ack(10, ack, n);
        tick();
        req_valid = '0;
        for (int a = 0; a < 4; a++) begin
            wait_start(30, n);
            gen_reply(2, 0);
        end
        @(negedge clk);
        check("s4_fail", {tx_fail, tx_done}, {4'b1000, 4'b0000});
        check("s4_retry_cnt", retry_cnt, 3);
        wait_idle(40);

        // Timeout, then gap restart on bus activity
        p0 = mk(11'h010, 64'h1111_1111_1111_1111);
        req_payload[0 +: 75] = p0;
        exp_q.push_back(ev(EV_ACK, 0, p0));
        repeat (3) exp_q.push_back(ev(EV_START, 0, p0));
        exp_q.push_back(ev(EV_DONE, 0, p0));
        tick();
        req_valid = 4'b0001;
        wait_ack(10, ack, n);
        tick();
        req_valid = '0;
        wait_start(5, n);
        wait_start(400, n);
        check("s5_timeout_restart", n, 267);
        gen_reply(3, 0);
        repeat (5) tick();
        bus_idle = 1'b0;
        tick();
        bus_idle = 1'b1;
        wait_start(40, n);
        check("s5_gap_restart", n, 12);
        gen_reply(3, 1);
        wait_idle(40);

        // Reset mid-WAIT with request still valid
        p2 = mk(11'h050, 64'h2222_2222_2222_2222);
        req_payload[150 +: 75] = p2;
        exp_q.push_back(ev(EV_ACK, 2, p2));
        exp_q.push_back(ev(EV_START, 2, p2));
        tick();
        req_valid = 4'b0100;
        wait_ack(10, ack, n);
        wait_start(5, n);
        repeat (10) tick();
        rst = 1'b0;
        gen_ok = 1'b1;
        tick();
        gen_ok = 1'b0;
        tick();
        check("s6_rst_busy", busy, 0);
        check("s6_rst_payload", gen_payload, 0);
        check("s6_rst_pulses", {req_ack, tx_done, tx_fail, gen_start}, 0);
        check("s6_rst_counters", {grant_idx, retry_cnt, state_o}, 0);
        exp_q.push_back(ev(EV_ACK, 2, p2));
        exp_q.push_back(ev(EV_START, 2, p2));
        exp_q.push_back(ev(EV_DONE, 2, p2));
        rst = 1'b1;
        wait_ack(10, ack, n);
        check("s6_regrant", ack, 4'b0100);
        tick();
        req_valid = '0;
        wait_start(5, n);
        gen_reply(4, 1);
        wait_idle(40);

        repeat (5) tick();
        check("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/can_tx_scheduler.md
Name: can_tx_scheduler

Overview:
- Shares one CAN frame generator between N_REQ requesters (e.g. per-channel ADC readout, SDO responses).
- Each requester presents an 11-bit CAN ID plus 64-bit data. The scheduler grants the lowest ID (CAN priority), loads the generator and issues a start pulse.
- It waits for the generator's result, retransmits on error up to MAX_RETRY times, and enforces an inter-frame gap of idle bus before the next frame.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- MAX_RETRY, 3, retransmissions after the first attempt before reporting failure.
- IFS_CYCLES, 11, consecutive bus_idle cycles required between frames.
- TIMEOUT, 255, cycles in WAIT with no gen_ok/gen_err before the attempt is treated as an error.

Ports:
- clk, in, 1, clock.
- rst, in, 1, reset: asynchronous, active-low.
- req_valid, in, N_REQ, request pending per requester; payload held stable until req_ack.
- req_payload, in, N_REQ*75, per requester i at [75*i+74 : 75*i]: {id[10:0], data[63:0]}.
- req_ack, out, N_REQ, one-cycle pulse when the request is captured.
- tx_done, out, N_REQ, one-cycle pulse: frame of requester i acknowledged on bus.
- tx_fail, out, N_REQ, one-cycle pulse: retries exhausted for requester i.
- gen_payload, out, 76, to generator: {1'b0, id[10:0], data[63:0]}.
- gen_start, out, 1, one-cycle start pulse to generator.
- gen_ok, in, 1, pulse: frame sent and ACK seen.
- gen_err, in, 1, pulse: ACK error, bit error or arbitration lost.
- bus_idle, in, 1, bus recessive / idle indication.
- busy, out, 1, high in every state except IDLE.
- grant_idx, out, 3, index of the current owner.
- retry_cnt, out, 3, retries used for the current frame.

Behaviour:
- Reset: async, active-low. All outputs 0 (gen_payload 76'h0), FSM to IDLE, counters 0. Assertion mid-frame drops the frame silently: no done/fail pulse.
- States: IDLE, LOAD, START, WAIT, GAP.
- IDLE:
  - If any req_valid and bus_idle: winner = valid requester with lowest id; tie → lowest index.
  - On the same edge: grant_idx <= winner, gen_payload <= winner payload, retry_cnt <= 0, → LOAD.
  - req_ack[winner] is high during the LOAD cycle (exactly 1 cycle).
- LOAD → START. START: gen_start=1 for exactly one cycle, timeout counter cleared, → WAIT.
- WAIT (each cycle):
  - gen_ok: tx_done[grant_idx] pulse, retry pending cleared, → GAP.
  - gen_err, or timeout counter reaching TIMEOUT:
    - If retry_cnt < MAX_RETRY: retry_cnt+1, retry pending set, → GAP.
    - Else: tx_fail[grant_idx] pulse, → GAP.
  - gen_ok and gen_err in the same cycle: gen_ok wins.
- GAP:
  - Counts consecutive bus_idle cycles; the counter restarts at 0 whenever bus_idle=0.
  - At IFS_CYCLES: retry pending → START (same gen_payload, no re-arbitration, no new req_ack); else → IDLE.
- gen_payload is stable from LOAD until the next LOAD; retransmission reuses it unchanged.
- Deasserting req_valid after req_ack has no effect on the in-flight frame. req_valid of the granted requester re-asserted during the frame is considered only back in IDLE.
- Done/fail latency: tx_done/tx_fail asserted 1 cycle after the gen_ok/gen_err cycle (registered).
- Pulses on gen_ok/gen_err outside WAIT are ignored.
- Minimum request-to-start latency: 3 cycles (IDLE capture, LOAD, START).

Test Plan:
- Single request: req_valid=4'b0001, id=11'h581, data=64'h0123456789ABCDEF, bus_idle=1 → req_ack[0] 1 cycle; gen_payload=76'h5810123456789ABCDEF; gen_start pulse; gen_ok after 120 cycles → tx_done[0] pulse; busy low after 11 idle cycles.
- Priority: req0 id=11'h600, req2 id=11'h181 both valid → req2 granted first; req0 granted only after req2's gap. Equal ids 11'h181 on req1 and req3 → req1 first.
- Retry: gen_err on attempts 1 and 2, gen_ok on attempt 3 → 3 gen_start pulses, identical gen_payload each time, retry_cnt=2, tx_done once, no extra req_ack.
- Exhaustion: gen_err on every attempt with MAX_RETRY=3 → 4 gen_start pulses, then tx_fail[grant_idx] pulse, no tx_done.
- Timeout and gap: no gen_ok/gen_err for 255 cycles → counted as an error. bus_idle dropped at gap cycle 6 → gap restarts; next gen_start only after 11 consecutive idle cycles.
- Reset mid-WAIT: rst low for 2 cycles → all outputs 0, IDLE, no done/fail. A still-valid request is re-granted after release.
